// File: rtl/jtag_master_pkg.sv
// jtag_master_pkg: command ops, sequencer states and TMS header patterns
// shared by the JTAG master control files.
package jtag_master_pkg;

    typedef enum logic [1:0] {
        OP_RESET = 2'b00,
        OP_IR    = 2'b01,
        OP_DR    = 2'b10,
        OP_IDLE  = 2'b11
    } cmd_op_e;

    typedef enum logic [2:0] {
        S_AUTO_RST,
        S_IDLE,
        S_RST_SEQ,
        S_HDR,
        S_SHIFT,
        S_TAIL,
        S_IDLE_CLK,
        S_DONE
    } state_e;

    localparam int         RESET_ONES = 5;
    localparam logic [3:0] IR_HDR_TMS = 4'b0011;
    localparam logic [2:0] DR_HDR_TMS = 3'b001;

endpackage

// File: rtl/jtag_master_ctrl_if.sv
// jtag_master_ctrl_if: command/response port of the JTAG master.
interface jtag_master_ctrl_if #(
    parameter int REGISTER_SIZE = 32,
    parameter int LEN_W         = $clog2(REGISTER_SIZE + 1)
) ();
    import jtag_master_pkg::*;

    logic                     CMD_VALID;
    logic                     CMD_READY;
    cmd_op_e                  CMD_OP;
    logic [LEN_W-1:0]         CMD_LEN;
    logic [REGISTER_SIZE-1:0] CMD_DATA;
    logic                     RSP_VALID;
    logic [REGISTER_SIZE-1:0] RSP_DATA;

    modport master (
        output CMD_VALID, CMD_OP, CMD_LEN, CMD_DATA,
        input  CMD_READY, RSP_VALID, RSP_DATA
    );

    modport slave (
        input  CMD_VALID, CMD_OP, CMD_LEN, CMD_DATA,
        output CMD_READY, RSP_VALID, RSP_DATA
    );
endinterface

// File: rtl/jtag_master_tck_gen.sv
// jtag_master_tck_gen: TCK at CLK/2 while enabled, parked low otherwise.
module jtag_master_tck_gen (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tck_o,
    output logic rise_stb_o,
    output logic fall_stb_o
);
    logic tck_q, tck_d;

    // Strobes mark the CLK edge that is about to move TCK.
    assign rise_stb_o = en_i && !tck_q;
    assign fall_stb_o = en_i && tck_q;
    assign tck_d      = en_i ? !tck_q : 1'b0;
    assign tck_o      = tck_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tck_q <= 1'b0;
        end else begin
            tck_q <= tck_d;
        end
    end
endmodule

// File: rtl/jtag_master_ctrl.sv
// jtag_master_ctrl: command-driven JTAG TAP sequencer, TCK = CLK/2.
// Define JTAG_MASTER_CAPTURE_EN to return captured TDO on RSP_DATA.
module jtag_master_ctrl
    import jtag_master_pkg::*;
#(
    parameter int REGISTER_SIZE = 32,
    parameter int LEN_W         = $clog2(REGISTER_SIZE + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    jtag_master_ctrl_if.slave bus,
    output logic              BUSY,
    output logic              TCK,
    output logic              TMS,
    output logic              TDI,
    input  logic              TDO
);
    localparam int IDX_W = $clog2(REGISTER_SIZE);

    state_e                   state_q, state_d;
    cmd_op_e                  op_q, op_d;
    logic [LEN_W-1:0]         cnt_q, cnt_d, len_q, len_d;
    logic [LEN_W-1:0]         len_c, seg_last;
    logic [REGISTER_SIZE-1:0] data_q, data_d;
    logic [3:0]               hdr_tms;
    logic                     tms_q, tms_d, tdi_q, tdi_d;
    logic                     arm_q, run, fire, last;
    logic                     rise_stb, fall_stb;

    // arm_q holds off TCK for one cycle so auto-reset lines up with commands
    assign run  = (state_q != S_IDLE) && (state_q != S_DONE) && !arm_q;
    assign fire = bus.CMD_VALID && bus.CMD_READY;
    assign len_c = (bus.CMD_LEN > LEN_W'(REGISTER_SIZE)) ?
                   LEN_W'(REGISTER_SIZE) : bus.CMD_LEN;
    assign last = (cnt_q == seg_last);
    assign hdr_tms = (op_d == OP_IR) ? IR_HDR_TMS : {1'b0, DR_HDR_TMS};

    assign bus.CMD_READY = (state_q == S_IDLE) || (state_q == S_DONE);
    assign bus.RSP_VALID = (state_q == S_DONE);
    assign BUSY = (state_q != S_IDLE);
    assign TMS  = tms_q;
    assign TDI  = tdi_q;

    jtag_master_tck_gen u_tck (
        .clk_i      (CLK),
        .rst_i      (RST),
        .en_i       (run),
        .tck_o      (TCK),
        .rise_stb_o (rise_stb),
        .fall_stb_o (fall_stb)
    );

    always_comb begin
        seg_last = '0;
        unique case (state_q)
            S_AUTO_RST, S_RST_SEQ: seg_last = LEN_W'(RESET_ONES);
            S_HDR: seg_last = (op_q == OP_IR) ? LEN_W'(3) : LEN_W'(2);
            S_SHIFT, S_IDLE_CLK: seg_last = len_q - LEN_W'(1);
            S_TAIL: seg_last = LEN_W'(1);
            default: seg_last = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        len_d   = len_q;
        data_d  = data_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (fire) begin
                    op_d   = bus.CMD_OP;
                    len_d  = len_c;
                    data_d = bus.CMD_DATA;
                    cnt_d  = '0;
                    if (bus.CMD_OP == OP_RESET) state_d = S_RST_SEQ;
                    else if (len_c == '0)       state_d = S_DONE;
                    else if (bus.CMD_OP == OP_IDLE) state_d = S_IDLE_CLK;
                    else                        state_d = S_HDR;
                end
            end
            default: begin
                if (fall_stb) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (last) begin
                        cnt_d = '0;
                        unique case (state_q)
                            S_AUTO_RST: state_d = S_IDLE;
                            S_HDR:      state_d = S_SHIFT;
                            S_SHIFT:    state_d = S_TAIL;
                            default:    state_d = S_DONE;
                        endcase
                    end
                end
            end
        endcase
    end

    // Pin values for the bit being entered; unchanged while a bit is held.
    always_comb begin
        tms_d = 1'b0;
        tdi_d = 1'b0;
        unique case (state_d)
            S_AUTO_RST, S_RST_SEQ: tms_d = (cnt_d < LEN_W'(RESET_ONES));
            S_HDR: tms_d = hdr_tms[cnt_d[1:0]];
            S_SHIFT: begin
                tms_d = (cnt_d == len_d - LEN_W'(1));
                tdi_d = data_d[cnt_d[IDX_W-1:0]];
            end
            S_TAIL: tms_d = (cnt_d == '0);
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_AUTO_RST;
            op_q    <= OP_RESET;
            cnt_q   <= '0;
            len_q   <= '0;
            data_q  <= '0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
            arm_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            data_q  <= data_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            arm_q   <= 1'b0;
        end
    end

`ifdef JTAG_MASTER_CAPTURE_EN
    logic [REGISTER_SIZE-1:0] cap_q, rsp_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cap_q <= '0;
            rsp_q <= '0;
        end else begin
            if (fire) begin
                cap_q <= '0;
            end else if (rise_stb && state_q == S_SHIFT) begin
                cap_q[cnt_q[IDX_W-1:0]] <= TDO;
            end
            if (state_d == S_DONE) begin
                rsp_q <= fire ? '0 : cap_q;
            end
        end
    end

    assign bus.RSP_DATA = rsp_q;
`else
    logic unused_cap;

    assign unused_cap   = TDO ^ rise_stb;
    assign bus.RSP_DATA = '0;
`endif

endmodule

// File: tb/tb_jtag_master_ctrl.sv
// tb_jtag_master_ctrl: vector table with scoreboard plus hand-written
// sequences for auto-reset, mid-command reset and back-to-back commands.
module tb_jtag_master_ctrl;
    import jtag_master_pkg::*;

`ifdef JTAG_MASTER_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  len;
        logic [31:0] data;
        logic        tdo;
        int          ntck;
        logic [63:0] tms;
        logic [63:0] tdi;
        int          rcyc;
        logic [31:0] rsp;
    } vec_t;

    typedef struct {
        int          ntck;
        logic [63:0] tms;
        logic [63:0] tdi;
        int          rcyc;
        logic [31:0] rsp;
    } exp_t;

    logic clk, rst, busy, tck, tms, tdi, tdo;
    int   n_chk, n_pass;
    exp_t sb[$];
    vec_t vt[8];

    jtag_master_ctrl_if #(.REGISTER_SIZE(32)) bus ();

    jtag_master_ctrl #(.REGISTER_SIZE(32)) dut (
        .CLK  (clk),
        .RST  (rst),
        .bus  (bus),
        .BUSY (busy),
        .TCK  (tck),
        .TMS  (tms),
        .TDI  (tdi),
        .TDO  (tdo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic wait_ready(input string nm);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.CMD_READY) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_chk++;
            $display("FAIL %s: CMD_READY got 0 expected 1", nm);
        end
    endtask

    // Samples at negedge; records TMS/TDI at each TCK rise.
    task automatic observe(input bit stop_rdy, output int nt,
                           output logic [63:0] ts, output logic [63:0] ds,
                           output int ec, output logic tk,
                           output logic [31:0] rd, output bit sr);
        logic prev;
        prev = 1'b0;
        nt = 0; ts = '0; ds = '0; ec = -1; tk = 1'bx; rd = 'x; sr = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (tck && !prev) begin
                if (nt < 64) begin
                    ts[nt] = tms;
                    ds[nt] = tdi;
                end
                nt++;
            end
            prev = tck;
            if (bus.RSP_VALID) sr = 1'b1;
            if (stop_rdy ? bus.CMD_READY : bus.RSP_VALID) begin
                ec = c;
                tk = tck;
                rd = bus.RSP_DATA;
                break;
            end
        end
    endtask

    task automatic autorst_chk(input string nm);
        int nt, ec;
        logic [63:0] ts, ds;
        logic tk;
        logic [31:0] rd;
        bit sr;
        observe(1'b1, nt, ts, ds, ec, tk, rd, sr);
        chk({nm, " ready cycle"}, 64'(ec), 64'(13));
        chk({nm, " ntck"}, 64'(nt), 64'(6));
        chk({nm, " tms"}, ts, 64'h1F);
        chk({nm, " no rsp"}, 64'(sr), 64'(0));
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int nt, ec;
        logic [63:0] ts, ds;
        logic tk;
        logic [31:0] rd;
        bit sr;
        exp_t e;
        wait_ready($sformatf("v%0d ready", idx));
        tdo           = v.tdo;
        bus.CMD_OP    = cmd_op_e'(v.op);
        bus.CMD_LEN   = v.len;
        bus.CMD_DATA  = v.data;
        bus.CMD_VALID = 1'b1;
        @(posedge clk);
        sb.push_back('{v.ntck, v.tms, v.tdi, v.rcyc, v.rsp});
        #1;
        bus.CMD_VALID = 1'b0;
        bus.CMD_DATA  = ~v.data;
        bus.CMD_OP    = cmd_op_e'(~v.op);
        bus.CMD_LEN   = 6'd63;
        observe(1'b0, nt, ts, ds, ec, tk, rd, sr);
        e = sb.pop_front();
        chk($sformatf("v%0d ntck", idx), 64'(nt), 64'(e.ntck));
        chk($sformatf("v%0d tms", idx), ts, e.tms);
        chk($sformatf("v%0d tdi", idx), ds, e.tdi);
        chk($sformatf("v%0d rsp cycle", idx), 64'(ec), 64'(e.rcyc));
        chk($sformatf("v%0d tck at rsp", idx), 64'(tk), 64'(0));
        chk($sformatf("v%0d rsp data", idx), 64'(rd), 64'(e.rsp));
    endtask

    initial begin
        int nt, r1, r2, hi;
        logic prev, tms_or;

        vt[0] = '{2'd0, 6'd7, 32'h1234_5678, 1'b0, 6, 64'h1F, 64'h0,
                  13, 32'h0};
        vt[1] = '{2'd1, 6'd4, 32'h0000_0001, 1'b0, 10, 64'h183, 64'h10,
                  21, 32'h0};
        vt[2] = '{2'd2, 6'd32, 32'hA5C3_0F96, 1'b1, 37, 64'hC_0000_0001,
                  64'hA5C3_0F96 << 3, 75, CAP ? 32'hFFFF_FFFF : 32'h0};
        vt[3] = '{2'd2, 6'd0, 32'hFFFF_FFFF, 1'b1, 0, 64'h0, 64'h0,
                  1, 32'h0};
        vt[4] = '{2'd2, 6'd40, 32'hFFFF_FFFF, 1'b0, 37, 64'hC_0000_0001,
                  64'hFFFF_FFFF << 3, 75, 32'h0};
        vt[5] = '{2'd1, 6'd1, 32'h0000_0001, 1'b1, 7, 64'h33, 64'h10,
                  15, CAP ? 32'h1 : 32'h0};
        vt[6] = '{2'd3, 6'd5, 32'hFFFF_FFFF, 1'b1, 5, 64'h0, 64'h0,
                  11, 32'h0};
        vt[7] = '{2'd2, 6'd8, 32'h0000_005A, 1'b1, 13, 64'hC01, 64'h2D0,
                  27, CAP ? 32'hFF : 32'h0};

        n_chk = 0;
        n_pass = 0;
        rst = 1'b0;
        tdo = 1'b0;
        bus.CMD_VALID = 1'b0;
        bus.CMD_OP    = OP_RESET;
        bus.CMD_LEN   = '0;
        bus.CMD_DATA  = '0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset pins", {tck, tms, tdi, bus.CMD_READY, bus.RSP_VALID, busy},
            6'b010001);
        chk("reset rsp data", 64'(bus.RSP_DATA), 64'h0);
        rst = 1'b0;
        autorst_chk("autorst");

        foreach (vt[i]) run_vec(vt[i], i);

        repeat (4) @(negedge clk);
        chk("rsp hold", 64'(bus.RSP_DATA), CAP ? 64'hFF : 64'h0);

        // Reset asserted during shift bit 10 of a 32-bit DR shift.
        wait_ready("mid ready");
        tdo           = 1'b1;
        bus.CMD_OP    = OP_DR;
        bus.CMD_LEN   = 6'd32;
        bus.CMD_DATA  = 32'hFFFF_0000;
        bus.CMD_VALID = 1'b1;
        @(posedge clk);
        #1 bus.CMD_VALID = 1'b0;
        nt = 0;
        prev = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (tck && !prev) nt++;
            prev = tck;
            if (nt == 14) break;
        end
        chk("mid rise count", 64'(nt), 64'(14));
        #2 rst = 1'b1;
        #1;
        chk("mid rst pins", {tck, tms, tdi, bus.CMD_READY, bus.RSP_VALID, busy},
            6'b010001);
        chk("mid rst rsp data", 64'(bus.RSP_DATA), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        autorst_chk("rerun autorst");

        // Two idle-clock commands with CMD_VALID held high.
        wait_ready("b2b ready");
        bus.CMD_OP    = OP_IDLE;
        bus.CMD_LEN   = 6'd3;
        bus.CMD_VALID = 1'b1;
        @(posedge clk);
        r1 = -1; r2 = -1; hi = -1; nt = 0;
        prev = 1'b0;
        tms_or = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (tck && !prev) nt++;
            prev = tck;
            tms_or = tms_or | tms;
            if (r1 > 0 && hi < 0 && tck) hi = c;
            if (r1 > 0 && c == r1 + 1) bus.CMD_VALID = 1'b0;
            if (bus.RSP_VALID) begin
                if (r1 < 0) r1 = c;
                else if (r2 < 0) r2 = c;
            end
            if (r2 > 0) break;
        end
        bus.CMD_VALID = 1'b0;
        chk("b2b first rsp", 64'(r1), 64'(7));
        chk("b2b second rise", 64'(hi), 64'(9));
        chk("b2b second rsp", 64'(r2), 64'(14));
        chk("b2b ntck", 64'(nt), 64'(6));
        chk("b2b tms", 64'(tms_or), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/jtag_master_ctrl.md
# jtag_master_ctrl

Command-driven JTAG master that sequences the TAP controller (TCK/TMS/TDI/TDO) of the `jtag` block from a simple valid/ready command port. It turns high-level operations (TAP reset, shift IR, shift DR, idle clocks) into the exact TMS/TDI bit streams. It generates TCK at half the system clock, captures TDO and returns shifted-out data on a response pulse. It sits between on-chip control logic (or a host bridge) and the TAP pins.

## Interface
- `REGISTER_SIZE`, 32: maximum shift length in bits and width of `CMD_DATA`/`RSP_DATA`.
- `LEN_W`, `$clog2(REGISTER_SIZE+1)`: width of `CMD_LEN`.
- `CLK` input 1: system clock; one clock, all logic on its rising edge.
- `RST` input 1: reset, asynchronous, active-high.
- `CMD_VALID` input 1: command offered.
- `CMD_READY` output 1: command accepted when `CMD_VALID && CMD_READY`.
- `CMD_OP` input 2: 00 TAP reset, 01 shift IR, 10 shift DR, 11 idle clocks.
- `CMD_LEN` input `LEN_W`: bit count for shift and idle ops; ignored for reset.
- `CMD_DATA` input `REGISTER_SIZE`: shift-in data, LSB first.
- `RSP_VALID` output 1: one-cycle pulse at command completion; no backpressure.
- `RSP_DATA` output `REGISTER_SIZE`: captured TDO, right-justified in bits `LEN-1:0`, upper bits 0.
- `BUSY` output 1: high whenever not in IDLE.
- `TCK`, `TMS`, `TDI` output 1: drive the TAP.
- `TDO` input 1: from the TAP.

## Operation
- Reset values: `TCK`=0, `TMS`=1, `TDI`=0, `CMD_READY`=0, `RSP_VALID`=0, `RSP_DATA`=0, `BUSY`=1.
- After `RST` deasserts, the block runs the auto-reset sequence: TMS 1,1,1,1,1,0 (6 TCK), leaving the TAP in Run-Test/Idle. It does not pulse `RSP_VALID`. It then enters IDLE.
- States: AUTO_RST, IDLE, RST_SEQ, HDR (Select/Capture path), SHIFT, TAIL (Update, return to RTI), IDLE_CLK, DONE.
- IDLE: `CMD_READY`=1, TCK parked low, TMS=0. Every command starts from and returns to Run-Test/Idle.
- Op 00: TMS 1,1,1,1,1,0.
- Op 01: header TMS 1,1,0,0; then `LEN` shift bits with TMS=0, except the last bit with TMS=1; tail TMS 1,0. Total `LEN`+6 TCK.
- Op 10: header TMS 1,0,0; shift as for op 01; tail TMS 1,0. Total `LEN`+5 TCK.
- Op 11: `LEN` TCK with TMS=0.
- During shift bit k, TDI = `CMD_DATA[k]`. TDI is 0 outside SHIFT.
- TDO is sampled on each shift bit into `RSP_DATA[k]`.
- `LEN`=0 for ops 01/10/11: no TCK, DONE on the next cycle, `RSP_DATA`=0.
- `LEN` > `REGISTER_SIZE` is clamped to `REGISTER_SIZE`.
- `CMD_DATA`, `CMD_OP` and the clamped `LEN` are latched at acceptance. Input changes afterwards have no effect.
- DONE: `RSP_VALID`=1 for one cycle with `RSP_DATA` stable. `RSP_DATA` holds until the next completion. `CMD_READY`=1 in the same cycle.
- `RST` mid-command: outputs return immediately to their reset values. The command is dropped with no response. The auto-reset sequence reruns.

## Timing
- Each TCK period is 2 `CLK` cycles.
- On the fall edge (TCK 1→0, or the first low cycle), TMS and TDI update.
- On the rise edge (TCK 0→1), TDO is registered in the same `CLK` edge.
- Command accepted at cycle 0; bit k is low in cycle 2k+1 and high in cycle 2k+2.
- For N TCK, `RSP_VALID` is high at cycle 2N+1 with TCK=0.
- A command accepted in the DONE cycle starts its first bit on the next cycle. There are no extra idle TCKs between back-to-back commands.
- Auto-reset: `CMD_READY` rises 13 cycles after `RST` deasserts.

## Configuration
- `JTAG_MASTER_CAPTURE_EN` defined: TDO capture register present; `RSP_DATA` behaves as above.
- Undefined: no capture register; `RSP_DATA` is tied to 0. `RSP_VALID` and all TCK/TMS/TDI behaviour are unchanged.

## Structure
- Package `jtag_master_pkg` contains:
  - the `CMD_OP` enum;
  - the state enum;
  - constants `RESET_ONES`=5, `IR_HDR_TMS`=4'b0011 (LSB-first 1,1,0,0), `DR_HDR_TMS`=3'b001.
- Sub-module `jtag_master_tck_gen` holds the phase toggle and the TCK register. It exports `fall_stb`/`rise_stb` when run-enabled.

## Test plan
- Release `RST` → TMS 1,1,1,1,1,0 over 6 TCK; `CMD_READY`=1 at cycle 13; no `RSP_VALID`.
- Op 01, `LEN`=4, `CMD_DATA`=4'b0001 → 10 TCK with TMS 1,1,0,0,0,0,0,1,1,0. TDI is 1,0,0,0 during the shift bits. `RSP_VALID` at cycle 21.
- Op 10, `LEN`=32, `TDO` tied 1 → 37 TCK; `RSP_VALID` at cycle 75; `RSP_DATA`=32'hFFFF_FFFF (0 when `JTAG_MASTER_CAPTURE_EN` is undefined).
- Op 10, `LEN`=0 → `RSP_VALID` at cycle 1, `RSP_DATA`=0, no TCK.
- Op 10, `LEN`=40 → clamped to 32 (37 TCK).
- `RST` pulsed during shift bit 10 of a DR shift → `TCK`=0 and `TMS`=1 immediately; no response; auto-reset reruns.
- `CMD_VALID` held high with two op 11 `LEN`=3 commands → second accepted in the first command's DONE cycle. Its first TCK rises at cycle 9 relative to the first acceptance.
